// File: rtl/chimera_axi_scratch_responder.sv
// AXI4 scratch-memory responder: independent single-outstanding read and write engines
// over a flop-based word array, INCR/FIXED bursts, SLVERR for out-of-window or WRAP/reserved.
package chimera_axi_scratch_pkg;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned AddrWidth = 48;
    localparam int unsigned IdWidth   = 4;

    typedef struct packed {
        logic [IdWidth-1:0]     aw_id;
        logic [AddrWidth-1:0]   aw_addr;
        logic [7:0]             aw_len;
        logic [2:0]             aw_size;
        logic [1:0]             aw_burst;
        logic                   aw_valid;
        logic [DataWidth-1:0]   w_data;
        logic [DataWidth/8-1:0] w_strb;
        logic                   w_last;
        logic                   w_valid;
        logic                   b_ready;
        logic [IdWidth-1:0]     ar_id;
        logic [AddrWidth-1:0]   ar_addr;
        logic [7:0]             ar_len;
        logic [2:0]             ar_size;
        logic [1:0]             ar_burst;
        logic                   ar_valid;
        logic                   r_ready;
    } axi_req_t;

    typedef struct packed {
        logic                 aw_ready;
        logic                 w_ready;
        logic [IdWidth-1:0]   b_id;
        logic [1:0]           b_resp;
        logic                 b_valid;
        logic                 ar_ready;
        logic [IdWidth-1:0]   r_id;
        logic [DataWidth-1:0] r_data;
        logic [1:0]           r_resp;
        logic                 r_last;
        logic                 r_valid;
    } axi_rsp_t;
endpackage

module chimera_axi_scratch_responder #(
    parameter int unsigned          DataWidth = 64,
    parameter int unsigned          AddrWidth = 48,
    parameter int unsigned          IdWidth   = 4,
    parameter int unsigned          NumWords  = 64,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0,
    parameter type axi_req_t = chimera_axi_scratch_pkg::axi_req_t,
    parameter type axi_rsp_t = chimera_axi_scratch_pkg::axi_rsp_t
) (
    input  logic     soc_clk_i,
    input  logic     rst_ni,
    input  axi_req_t axi_req_i,
    output axi_rsp_t axi_rsp_o
);
    localparam int unsigned          StrbWidth = DataWidth / 8;
    localparam int unsigned          OffWidth  = $clog2(StrbWidth);
    localparam int unsigned          IdxWidth  = $clog2(NumWords);
    localparam logic [AddrWidth-1:0] Stride    = AddrWidth'(StrbWidth);
    localparam logic [AddrWidth-1:0] WinBytes  = AddrWidth'(NumWords * StrbWidth);
    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    function automatic logic beat_ok(input logic [AddrWidth-1:0] addr, input logic [1:0] burst);
        return ((burst == BurstFixed) || (burst == BurstIncr)) && ((addr - BaseAddr) < WinBytes);
    endfunction

    function automatic logic [IdxWidth-1:0] word_idx(input logic [AddrWidth-1:0] addr);
        return IdxWidth'((addr - BaseAddr) >> OffWidth);
    endfunction

    function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] addr,
                                                       input logic [1:0] burst);
        return (burst == BurstIncr) ? addr + Stride : addr;
    endfunction

    w_state_e             w_state_q, w_state_d;
    logic [IdWidth-1:0]   w_id_q, w_id_d;
    logic [AddrWidth-1:0] w_addr_q, w_addr_d;
    logic [7:0]           w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [1:0]           w_burst_q, w_burst_d;
    logic                 w_err_q, w_err_d;
    r_state_e             r_state_q, r_state_d;
    logic [IdWidth-1:0]   r_id_q, r_id_d;
    logic [AddrWidth-1:0] r_addr_q, r_addr_d;
    logic [7:0]           r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [1:0]           r_burst_q, r_burst_d;
    logic [DataWidth-1:0] mem_q [NumWords];
    logic [DataWidth-1:0] mem_d [NumWords];

    logic aw_ready, w_ready, b_valid, ar_ready, r_valid, r_ok, r_last;
    logic unused_fields;
    assign unused_fields = ^{axi_req_i.aw_size, axi_req_i.ar_size, axi_req_i.w_last};

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_burst_d = w_burst_q;
        w_err_d   = w_err_q;
        mem_d     = mem_q;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                aw_ready = 1'b1;
                if (axi_req_i.aw_valid) begin
                    w_id_d    = axi_req_i.aw_id;
                    w_addr_d  = axi_req_i.aw_addr;
                    w_len_d   = axi_req_i.aw_len;
                    w_burst_d = axi_req_i.aw_burst;
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                w_ready = 1'b1;
                if (axi_req_i.w_valid) begin
                    if (beat_ok(w_addr_q, w_burst_q)) begin
                        for (int b = 0; b < StrbWidth; b++) begin
                            if (axi_req_i.w_strb[b]) begin
                                mem_d[word_idx(w_addr_q)][8*b +: 8] = axi_req_i.w_data[8*b +: 8];
                            end
                        end
                    end else begin
                        w_err_d = 1'b1;
                    end
                    w_addr_d = next_addr(w_addr_q, w_burst_q);
                    w_cnt_d  = w_cnt_q + 8'd1;
                    // wlast is not trusted; the latched length alone ends the data phase
                    if (w_cnt_q == w_len_q) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                b_valid = 1'b1;
                if (axi_req_i.b_ready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_burst_d = r_burst_q;
        ar_ready  = 1'b0;
        r_valid   = (r_state_q == R_DATA);
        r_ok      = beat_ok(r_addr_q, r_burst_q);
        r_last    = (r_cnt_q == r_len_q);
        case (r_state_q)
            R_IDLE: begin
                ar_ready = 1'b1;
                if (axi_req_i.ar_valid) begin
                    r_id_d    = axi_req_i.ar_id;
                    r_addr_d  = axi_req_i.ar_addr;
                    r_len_d   = axi_req_i.ar_len;
                    r_burst_d = axi_req_i.ar_burst;
                    r_cnt_d   = '0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (axi_req_i.r_ready) begin
                    if (r_last) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d  = r_cnt_q + 8'd1;
                        r_addr_d = next_addr(r_addr_q, r_burst_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Handshake outputs are masked by reset so nothing is offered while rst_ni is low
    always_comb begin
        axi_rsp_o          = '0;
        axi_rsp_o.aw_ready = aw_ready & rst_ni;
        axi_rsp_o.w_ready  = w_ready & rst_ni;
        axi_rsp_o.b_valid  = b_valid & rst_ni;
        axi_rsp_o.b_id     = w_id_q;
        axi_rsp_o.b_resp   = w_err_q ? RespSlverr : RespOkay;
        axi_rsp_o.ar_ready = ar_ready & rst_ni;
        axi_rsp_o.r_valid  = r_valid & rst_ni;
        axi_rsp_o.r_id     = r_id_q;
        axi_rsp_o.r_data   = (r_valid && r_ok) ? mem_q[word_idx(r_addr_q)] : '0;
        axi_rsp_o.r_resp   = r_ok ? RespOkay : RespSlverr;
        axi_rsp_o.r_last   = r_valid & r_last;
    end

    always_ff @(posedge soc_clk_i) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_burst_q <= '0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_burst_q <= '0;
            for (int i = 0; i < NumWords; i++) mem_q[i] <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_burst_q <= r_burst_d;
            mem_q     <= mem_d;
        end
    end
endmodule

// File: tb/tb_chimera_axi_scratch_responder.sv
// Scoreboard bench for chimera_axi_scratch_responder: directed AXI transactions push expected
// B/R responses into queues that a negedge monitor pops on every handshake.
module tb_chimera_axi_scratch_responder;
    import chimera_axi_scratch_pkg::*;

    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    logic     clk = 1'b0;
    logic     rst_n;
    axi_req_t req;
    axi_rsp_t rsp;

    always #5 clk = ~clk;

    chimera_axi_scratch_responder #(
        .DataWidth(64), .AddrWidth(48), .IdWidth(4), .NumWords(64), .BaseAddr(48'h0)
    ) dut (
        .soc_clk_i(clk),
        .rst_ni   (rst_n),
        .axi_req_i(req),
        .axi_rsp_o(rsp)
    );

    typedef struct {logic [3:0] id; logic [1:0] resp;} b_exp_t;
    typedef struct {logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last;} r_exp_t;
    b_exp_t b_q[$];
    r_exp_t r_q[$];

    int checks   = 0;
    int failures = 0;

    logic [63:0] wd [8];
    logic [7:0]  ws [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: no handshake within cycle budget", name);
    endtask

    always @(negedge clk) begin : monitor
        b_exp_t be;
        r_exp_t re;
        if (rst_n === 1'b1) begin
            if (rsp.b_valid && req.b_ready) begin
                if (b_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_unexpected: got id 0x%0h with no pending write", rsp.b_id);
                end else begin
                    be = b_q.pop_front();
                    check("b_id", 64'(rsp.b_id), 64'(be.id));
                    check("b_resp", 64'(rsp.b_resp), 64'(be.resp));
                end
            end
            if (rsp.r_valid && req.r_ready) begin
                if (r_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL r_unexpected: got data 0x%0h with no pending read", rsp.r_data);
                end else begin
                    re = r_q.pop_front();
                    check("r_id", 64'(rsp.r_id), 64'(re.id));
                    check("r_data", rsp.r_data, re.data);
                    check("r_resp", 64'(rsp.r_resp), 64'(re.resp));
                    check("r_last", 64'(rsp.r_last), 64'(re.last));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [47:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        int n = 0;
        req.aw_id = id; req.aw_addr = addr; req.aw_len = len; req.aw_size = 3'd3;
        req.aw_burst = burst; req.aw_valid = 1'b1;
        do begin @(negedge clk); n++; end while (!rsp.aw_ready && n < 50);
        if (!rsp.aw_ready) timeout("aw_handshake");
        tick();
        req.aw_valid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n = 0;
        req.w_data = data; req.w_strb = strb; req.w_last = last; req.w_valid = 1'b1;
        do begin @(negedge clk); n++; end while (!rsp.w_ready && n < 50);
        if (!rsp.w_ready) timeout("w_handshake");
        tick();
        req.w_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [47:0] addr, input logic [7:0] len,
                           input logic [1:0] burst);
        int n = 0;
        req.ar_id = id; req.ar_addr = addr; req.ar_len = len; req.ar_size = 3'd3;
        req.ar_burst = burst; req.ar_valid = 1'b1;
        do begin @(negedge clk); n++; end while (!rsp.ar_ready && n < 50);
        if (!rsp.ar_ready) timeout("ar_handshake");
        tick();
        req.ar_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [47:0] addr, input int len,
                               input logic [1:0] burst, input logic [1:0] resp);
        b_q.push_back('{id, resp});
        send_aw(id, addr, 8'(len), burst);
        for (int i = 0; i <= len; i++) send_w(wd[i], ws[i], i == len);
    endtask

    task automatic exp_r(input logic [3:0] id, input logic [63:0] data, input logic [1:0] resp,
                         input logic last);
        r_q.push_back('{id, data, resp, last});
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((b_q.size() != 0 || r_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (b_q.size() != 0 || r_q.size() != 0) begin
            timeout(name);
            b_q.delete();
            r_q.delete();
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        req = '0;
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_aw_ready", 64'(rsp.aw_ready), 64'd0);
        check("rst_w_ready", 64'(rsp.w_ready), 64'd0);
        check("rst_ar_ready", 64'(rsp.ar_ready), 64'd0);
        check("rst_b_valid", 64'(rsp.b_valid), 64'd0);
        check("rst_r_valid", 64'(rsp.r_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // single-beat write with latency check, then read back
        b_q.push_back('{4'h1, OKAY});
        send_aw(4'h1, 48'h8, 8'd0, INCR);
        req.w_data = 64'hDEADBEEF_CAFEF00D; req.w_strb = 8'hFF; req.w_last = 1'b1;
        req.w_valid = 1'b1;
        @(negedge clk);
        check("t1_w_ready", 64'(rsp.w_ready), 64'd1);
        check("t1_b_early", 64'(rsp.b_valid), 64'd0);
        tick();
        req.w_valid = 1'b0;
        @(negedge clk);
        check("t1_b_latency", 64'(rsp.b_valid), 64'd1);
        wait_drain("t1_write");
        exp_r(4'h2, 64'hDEADBEEF_CAFEF00D, OKAY, 1'b1);
        send_ar(4'h2, 48'h8, 8'd0, INCR);
        wait_drain("t1_read");

        // INCR burst with partial strobe on the third beat
        wd[0] = 64'd1; wd[1] = 64'd2; wd[2] = 64'd3; wd[3] = 64'd4;
        ws[0] = 8'hFF; ws[1] = 8'hFF; ws[2] = 8'h0F; ws[3] = 8'hFF;
        write_burst(4'h4, 48'h0, 3, INCR, OKAY);
        exp_r(4'h6, 64'd1, OKAY, 1'b0);
        exp_r(4'h6, 64'd2, OKAY, 1'b0);
        exp_r(4'h6, 64'd3, OKAY, 1'b0);
        exp_r(4'h6, 64'd4, OKAY, 1'b1);
        send_ar(4'h6, 48'h0, 8'd3, INCR);
        wait_drain("t2");

        // byte strobes merge into an existing word
        wd[0] = 64'hFFFFFFFF_FFFFFFFF; ws[0] = 8'hFF;
        write_burst(4'h7, 48'h28, 0, INCR, OKAY);
        wd[0] = 64'h11112222_33334444; ws[0] = 8'h0F;
        write_burst(4'h7, 48'h28, 0, INCR, OKAY);
        exp_r(4'h8, 64'hFFFFFFFF_33334444, OKAY, 1'b1);
        send_ar(4'h8, 48'h28, 8'd0, INCR);
        wait_drain("t2_strb");

        // burst running off the end of the window
        exp_r(4'h9, 64'd0, OKAY, 1'b0);
        exp_r(4'h9, 64'd0, SLVERR, 1'b0);
        exp_r(4'h9, 64'd0, SLVERR, 1'b0);
        exp_r(4'h9, 64'd0, SLVERR, 1'b1);
        send_ar(4'h9, 48'h1F8, 8'd3, INCR);
        wait_drain("t3_read");
        wd[0] = 64'h6300; wd[1] = 64'h6301; wd[2] = 64'h6302; wd[3] = 64'h6303;
        for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
        write_burst(4'hA, 48'h1F8, 3, INCR, SLVERR);
        exp_r(4'hA, 64'h6300, OKAY, 1'b1);
        send_ar(4'hA, 48'h1F8, 8'd0, INCR);
        wait_drain("t3_write");

        // WRAP read, FIXED write, reserved-burst write leaves memory alone
        exp_r(4'hB, 64'd0, SLVERR, 1'b0);
        exp_r(4'hB, 64'd0, SLVERR, 1'b1);
        send_ar(4'hB, 48'h0, 8'd1, WRAP);
        wait_drain("t4_wrap");
        wd[0] = 64'd7; wd[1] = 64'd8; wd[2] = 64'd9;
        write_burst(4'hC, 48'h10, 2, FIXED, OKAY);
        wd[0] = 64'h55;
        write_burst(4'hC, 48'h10, 0, RSVD, SLVERR);
        exp_r(4'hD, 64'd9, OKAY, 1'b1);
        send_ar(4'hD, 48'h10, 8'd0, INCR);
        wait_drain("t4_fixed");

        // concurrent AW+AR with B/R backpressure
        req.b_ready = 1'b0;
        req.r_ready = 1'b0;
        b_q.push_back('{4'h3, OKAY});
        exp_r(4'h5, 64'd2, OKAY, 1'b1);
        req.aw_id = 4'h3; req.aw_addr = 48'h20; req.aw_len = 8'd0; req.aw_burst = INCR;
        req.ar_id = 4'h5; req.ar_addr = 48'h8;  req.ar_len = 8'd0; req.ar_burst = INCR;
        req.aw_valid = 1'b1;
        req.ar_valid = 1'b1;
        @(negedge clk);
        check("t5_aw_ready", 64'(rsp.aw_ready), 64'd1);
        check("t5_ar_ready", 64'(rsp.ar_ready), 64'd1);
        tick();
        req.aw_valid = 1'b0;
        req.ar_valid = 1'b0;
        send_w(64'hABCD, 8'hFF, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t5_b_valid", 64'(rsp.b_valid), 64'd1);
            check("t5_b_id", 64'(rsp.b_id), 64'h3);
            check("t5_r_valid", 64'(rsp.r_valid), 64'd1);
            check("t5_r_id", 64'(rsp.r_id), 64'h5);
            check("t5_r_data", rsp.r_data, 64'd2);
            check("t5_r_last", 64'(rsp.r_last), 64'd1);
        end
        tick();
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        wait_drain("t5");
        exp_r(4'h1, 64'hABCD, OKAY, 1'b1);
        send_ar(4'h1, 48'h20, 8'd0, INCR);
        wait_drain("t5_readback");

        // reset in the middle of a stalled read burst
        req.r_ready = 1'b0;
        send_ar(4'h7, 48'h0, 8'd3, INCR);
        @(negedge clk);
        check("t6_r_before", 64'(rsp.r_valid), 64'd1);
        tick();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_r_in_rst", 64'(rsp.r_valid), 64'd0);
        check("t6_ar_in_rst", 64'(rsp.ar_ready), 64'd0);
        tick();
        rst_n = 1'b1;
        req.r_ready = 1'b1;
        @(negedge clk);
        check("t6_r_after", 64'(rsp.r_valid), 64'd0);
        tick();
        exp_r(4'h2, 64'd0, OKAY, 1'b1);
        send_ar(4'h2, 48'h8, 8'd0, INCR);
        exp_r(4'h3, 64'd0, OKAY, 1'b1);
        send_ar(4'h3, 48'h1F8, 8'd0, INCR);
        exp_r(4'h4, 64'd0, OKAY, 1'b0);
        exp_r(4'h4, 64'd0, OKAY, 1'b1);
        send_ar(4'h4, 48'h20, 8'd1, INCR);
        wait_drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
